// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder: FSM encoding,
// wait-counter width and the request address error check.
package dmem_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    localparam int CNT_W = 4;
    localparam int LANES = 4;

    // Misaligned, or word index beyond the array; upper address bits never alias.
    function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth_words);
        logic [31:0] idx;
        idx = {2'b00, addr[31:2]};
        return (addr[1:0] != 2'b00) || (idx >= depth_words);
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// Word array with per-byte-lane synchronous write, one async read port for
// the responder and one async read port for the debug path. Not reset.
module dmem_bank
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic [LANES-1:0] we_i,
    input  logic [IDX_W-1:0] widx_i,
    input  logic [31:0]      wdata_i,
    input  logic [IDX_W-1:0] ridx_i,
    output logic [31:0]      rdata_o,
    input  logic [IDX_W-1:0] dbg_idx_i,
    output logic [31:0]      dbg_data_o
);

    logic [31:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (we_i[i]) begin
                mem_q[widx_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
    end

    assign rdata_o    = mem_q[ridx_i];
    assign dbg_data_o = mem_q[dbg_idx_i];

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder: valid/ready request, WAIT_STATES latency, held response.
// Optional MMIO register on mmio_out when DMEM_MMIO_EN is defined.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_STATES = 2,
    parameter logic [31:0] MMIO_ADDR   = 32'hFFFF_FF00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_we,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    input  logic [31:0] debug_addr,
    output logic [31:0] debug_data
`ifdef DMEM_MMIO_EN
    ,
    output logic [31:0] mmio_out
`endif
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam bit ZERO_WAIT = (WAIT_STATES == 0);
    localparam logic [CNT_W-1:0] CNT_INIT = ZERO_WAIT ? '0 : CNT_W'(WAIT_STATES - 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             rsp_valid_q;
    logic             rsp_err_q;
    logic             rsp_err_d;
    logic [31:0]      rsp_rdata_q;
    logic [31:0]      rsp_rdata_d;

    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        we_q;
    logic [3:0]  be_q;

    logic        accept;
    logic        enter_resp;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic        c_we;
    logic [3:0]  c_be;
    logic        c_err;
    logic        mmio_hit;
    logic [31:0] mmio_rdata;
    logic [3:0]  bank_we;
    logic [31:0] bank_rdata;
    logic [31:0] bank_dbg;
    logic        dbg_in_range;
    logic [1:0]  unused_dbg_lsb;

    assign req_ready  = (state_q == S_IDLE) || ((state_q == S_RESP) && rsp_ready);
    assign accept     = req_valid && req_ready;
    assign enter_resp = ZERO_WAIT ? accept : ((state_q == S_WAIT) && (cnt_q == '0));

    // Commit uses the live request when there is no wait, otherwise the latched copy.
    assign c_addr  = ZERO_WAIT ? req_addr  : addr_q;
    assign c_wdata = ZERO_WAIT ? req_wdata : wdata_q;
    assign c_we    = ZERO_WAIT ? req_we    : we_q;
    assign c_be    = ZERO_WAIT ? req_be    : be_q;

    assign c_err       = !mmio_hit && addr_err(c_addr, DEPTH_WORDS);
    assign bank_we     = (enter_resp && c_we && !c_err && !mmio_hit) ? c_be : 4'b0000;
    assign rsp_err_d   = c_err;
    assign rsp_rdata_d = (c_err || c_we) ? 32'h0 : (mmio_hit ? mmio_rdata : bank_rdata);

`ifdef DMEM_MMIO_EN
    logic [31:0] mmio_q;

    assign mmio_hit   = (c_addr == MMIO_ADDR);
    assign mmio_rdata = mmio_q;
    assign mmio_out   = mmio_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mmio_q <= 32'h0;
        end else if (enter_resp && c_we && mmio_hit) begin
            for (int i = 0; i < LANES; i++) begin
                if (c_be[i]) begin
                    mmio_q[8*i +: 8] <= c_wdata[8*i +: 8];
                end
            end
        end
    end
`else
    logic [31:0] unused_mmio_addr;

    assign mmio_hit         = 1'b0;
    assign mmio_rdata       = 32'h0;
    assign unused_mmio_addr = MMIO_ADDR;
`endif

    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            we_q    <= req_we;
            be_q    <= req_be;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else if (enter_resp) begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end else if (accept) begin
            state_q     <= S_WAIT;
            cnt_q       <= CNT_INIT;
            rsp_valid_q <= 1'b0;
        end else if (state_q == S_WAIT) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end else if ((state_q == S_RESP) && rsp_ready) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b0;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    assign dbg_in_range   = ({2'b00, debug_addr[31:2]} < 32'(DEPTH_WORDS));
    assign debug_data     = dbg_in_range ? bank_dbg : 32'h0;
    assign unused_dbg_lsb = debug_addr[1:0];

    dmem_bank #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_bank (
        .clk        (clk),
        .we_i       (bank_we),
        .widx_i     (c_addr[IDX_W+1:2]),
        .wdata_i    (c_wdata),
        .ridx_i     (c_addr[IDX_W+1:2]),
        .rdata_o    (bank_rdata),
        .dbg_idx_i  (debug_addr[IDX_W+1:2]),
        .dbg_data_o (bank_dbg)
    );

endmodule
